// File: rtl/dac_spi_pkg.sv
// Shared constants and state encoding for the dual-channel DAC SPI transmitter.
package dac_spi_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DATA_W  = 12;

    // MCP4922-style command nibbles: {A/B, BUF, GA_n, SHDN_n}
    localparam logic [3:0] CFG_A_DEF = 4'b0011;
    localparam logic [3:0] CFG_B_DEF = 4'b1011;

    // SETUP/SHIFT/HOLD are walked by the frame engine; the top uses SHIFT to mean
    // "a frame is on the wire" and owns IDLE/GAP/LDAC.
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap,
        StLdac
    } state_e;

endpackage

// File: rtl/dac_spi_tx_if.sv
// Waveform-side handshake plus DAC pin bundle for dac_spi_tx.
interface dac_spi_tx_if;

    logic                            start;
    logic [dac_spi_pkg::DATA_W-1:0]  dacA_word;
    logic [dac_spi_pkg::DATA_W-1:0]  dacB_word;
    logic                            busy;
    logic                            done;
    logic                            overrun;
    logic                            cs_n;
    logic                            sclk;
    logic                            mosi;
    logic                            ldac_n;

    // Upstream view: drives the strobe and words, observes status and pins.
    modport master (
        output start, dacA_word, dacB_word,
        input  busy, done, overrun, cs_n, sclk, mosi, ldac_n
    );

    // Transmitter view.
    modport slave (
        input  start, dacA_word, dacB_word,
        output busy, done, overrun, cs_n, sclk, mosi, ldac_n
    );

endinterface

// File: rtl/dac_spi_frame.sv
// Shifts one 16-bit SPI frame, mode 0, MSB first. The SETUP period doubles as the
// low phase ahead of the first rising edge; each bit then sits high CLK_DIV cycles
// and low CLK_DIV cycles, so mosi only moves as sclk falls.
module dac_spi_frame
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               cs_n,
    output logic               sclk,
    output logic               mosi,
    output logic               frame_done
);

    localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);
    localparam logic [4:0]     NBits   = 5'(FRAME_W);

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [4:0]           bit_q, bit_d;     // rising edges issued so far
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;

    // State and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next state, divider reload at each phase boundary, and next pin values.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StSetup;
                    div_d   = DivLoad;
                    bit_d   = '0;
                    shreg_d = frame_data;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = frame_data[FRAME_W-1];
                end
            end
            StSetup: begin
                if (div_q == '0) begin
                    state_d = StShift;
                    div_d   = DivLoad;
                    sclk_d  = 1'b1;
                    bit_d   = 5'd1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StShift: begin
                if (div_q == '0) begin
                    div_d = DivLoad;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // After the last bit mosi simply holds.
                        if (bit_q != NBits) begin
                            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                            mosi_d  = shreg_q[FRAME_W-2];
                        end
                    end else if (bit_q == NBits) begin
                        state_d = StHold;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StHold: begin
                if (div_q == '0) begin
                    state_d    = StIdle;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    frame_done = 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Sends channel A then channel B as two SPI frames, then pulses LDAC so both DAC
// outputs update together. Both words are captured on the accepted start.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2,
    parameter logic [3:0]  CFG_A   = CFG_A_DEF,
    parameter logic [3:0]  CFG_B   = CFG_B_DEF
) (
    input logic         clk,
    input logic         rst_n,
    dac_spi_tx_if.slave bus
);

    localparam int unsigned     CntMax  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned     CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DivLoad = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLoad = CntW'(CS_GAP - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                second_q, second_d;   // frame B is (or was last) on the wire
    logic [DATA_W-1:0]   word_b_q, word_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                ldac_n_q, ldac_n_d;
    logic                load;
    logic [FRAME_W-1:0]  frame_data;
    logic                frame_done;

    dac_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .frame_data (frame_data),
        .cs_n       (bus.cs_n),
        .sclk       (bus.sclk),
        .mosi       (bus.mosi),
        .frame_done (frame_done)
    );

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            second_q  <= 1'b0;
            word_b_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ldac_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            second_q  <= second_d;
            word_b_q  <= word_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ldac_n_q  <= ldac_n_d;
        end
    end

    // Frame A -> gap -> frame B -> gap -> LDAC -> idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        second_d   = second_q;
        word_b_d   = word_b_q;
        done_d     = 1'b0;
        ldac_n_d   = 1'b1;
        load       = 1'b0;
        frame_data = {CFG_A, bus.dacA_word};
        overrun_d  = bus.start && (state_q != StIdle);
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load     = 1'b1;
                    word_b_d = bus.dacB_word;
                    second_d = 1'b0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (frame_done) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    if (!second_q) begin
                        load       = 1'b1;
                        frame_data = {CFG_B, word_b_q};
                        second_d   = 1'b1;
                        state_d    = StShift;
                    end else begin
                        state_d  = StLdac;
                        ldac_n_d = 1'b0;
                        cnt_d    = DivLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLdac: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ldac_n_d = 1'b0;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
    assign bus.ldac_n  = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default timing instance plus a CLK_DIV=1/CS_GAP=1 one.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx_if bus_a ();
    dac_spi_tx_if bus_b ();

    dac_spi_tx dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dac_spi_tx #(
        .CLK_DIV (1),
        .CS_GAP  (1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Monitor state for instance A (cycle numbers relative to the start cycle t0_a).
    logic        clr_a = 1'b1;
    int          t0_a = 0;
    logic        prev_a;
    int          rises_a, ldac_first_a, ldac_last_a, ldac_cnt_a;
    int          done_cnt_a, ovr_cnt_a, busy_cnt_a, cs_low_a, bad_idle_a;
    logic [31:0] data_a;

    // Monitor state for instance B.
    logic        clr_b = 1'b1;
    int          t0_b = 0;
    logic        prev_b;
    int          rises_b, ldac_first_b, ldac_last_b, ldac_cnt_b;
    logic [31:0] data_b;

    // Capture mosi on each sclk rise and log strobes, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (clr_a) begin
            prev_a = 1'b0; rises_a = 0; data_a = '0; ldac_first_a = -1; ldac_last_a = -1;
            ldac_cnt_a = 0; done_cnt_a = 0; ovr_cnt_a = 0; busy_cnt_a = 0; cs_low_a = 0;
            bad_idle_a = 0;
        end else begin
            if (bus_a.sclk === 1'b1 && prev_a === 1'b0) begin
                rises_a++;
                data_a = {data_a[30:0], bus_a.mosi};
            end
            prev_a = bus_a.sclk;
            if (bus_a.ldac_n === 1'b0) begin
                if (ldac_cnt_a == 0) ldac_first_a = cyc - t0_a;
                ldac_last_a = cyc - t0_a;
                ldac_cnt_a++;
            end
            if (bus_a.done === 1'b1) done_cnt_a++;
            if (bus_a.overrun === 1'b1) ovr_cnt_a++;
            if (bus_a.busy === 1'b1) busy_cnt_a++;
            if (bus_a.cs_n === 1'b0) cs_low_a++;
            if (bus_a.cs_n !== 1'b1 || bus_a.sclk !== 1'b0 || bus_a.mosi !== 1'b0 ||
                bus_a.ldac_n !== 1'b1 || bus_a.busy !== 1'b0) bad_idle_a++;
        end
    end

    // Same capture for instance B.
    always @(negedge clk) begin
        if (clr_b) begin
            prev_b = 1'b0; rises_b = 0; data_b = '0; ldac_first_b = -1; ldac_last_b = -1;
            ldac_cnt_b = 0;
        end else begin
            if (bus_b.sclk === 1'b1 && prev_b === 1'b0) begin
                rises_b++;
                data_b = {data_b[30:0], bus_b.mosi};
            end
            prev_b = bus_b.sclk;
            if (bus_b.ldac_n === 1'b0) begin
                if (ldac_cnt_b == 0) ldac_first_b = cyc - t0_b;
                ldac_last_b = cyc - t0_b;
                ldac_cnt_b++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " cs_n"},   32'(bus_a.cs_n),   32'd1);
        chk({tag, " sclk"},   32'(bus_a.sclk),   32'd0);
        chk({tag, " mosi"},   32'(bus_a.mosi),   32'd0);
        chk({tag, " ldac_n"}, 32'(bus_a.ldac_n), 32'd1);
        chk({tag, " busy"},   32'(bus_a.busy),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.dacA_word = '0; bus_a.dacB_word = '0;
        bus_b.start = 1'b0; bus_b.dacA_word = '0; bus_b.dacB_word = '0;

        // Reset values, then 50 idle cycles.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_a("reset");
        chk("reset done", 32'(bus_a.done), 32'd0);
        chk("reset overrun", 32'(bus_a.overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("idle outputs", 32'(bad_idle_a), 32'd0);
        chk("idle rises", 32'(rises_a), 32'd0);

        // T1: defaults, words change mid-frame A, overrun at 50, restart in done cycle.
        bus_a.dacA_word = 12'hABC; bus_a.dacB_word = 12'h123;
        bus_a.start = 1'b1; clr_a = 1'b1; t0_a = cyc;
        for (int r = 1; r <= 143; r++) begin
            @(posedge clk); #1;
            clr_a = 1'b0;
            bus_a.start = (r == 50);
            if (r == 20) begin
                bus_a.dacA_word = 12'hFFF; bus_a.dacB_word = 12'hFFF;
            end
        end
        chk("t1 done@143", 32'(bus_a.done), 32'd1);
        chk("t1 busy@143", 32'(bus_a.busy), 32'd0);
        chk("t1 no early done", 32'(done_cnt_a), 32'd0);
        chk("t1 rises", 32'(rises_a), 32'd32);
        chk("t1 frames", data_a, 32'h3ABC_B123);
        chk("t1 ldac first", 32'(ldac_first_a), 32'd141);
        chk("t1 ldac last", 32'(ldac_last_a), 32'd142);
        chk("t1 ldac width", 32'(ldac_cnt_a), 32'd2);
        chk("t1 overrun count", 32'(ovr_cnt_a), 32'd1);
        chk("t1 busy cycles", 32'(busy_cnt_a), 32'd142);
        chk("t1 cs_n low cycles", 32'(cs_low_a), 32'd136);

        // T2: start in the done cycle, then reset during frame B bit 7.
        bus_a.dacA_word = 12'h555; bus_a.dacB_word = 12'hAAA;
        bus_a.start = 1'b1; clr_a = 1'b1; t0_a = cyc;
        for (int r = 1; r <= 104; r++) begin
            @(posedge clk); #1;
            clr_a = 1'b0;
            bus_a.start = 1'b0;
            if (r == 1) begin
                chk("t2 cs_n after done-cycle start", 32'(bus_a.cs_n), 32'd0);
                chk("t2 busy after done-cycle start", 32'(bus_a.busy), 32'd1);
            end
        end
        chk("t2 rises before reset", 32'(rises_a), 32'd24);
        chk("t2 bits before reset", {8'h00, data_a[23:0]}, 32'h0035_55BA);
        @(posedge clk); #1;
        chk("t2 sclk high before reset", 32'(bus_a.sclk), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_a("t2 async reset");
        for (int r = 106; r <= 160; r++) begin
            @(posedge clk); #1;
            if (r == 110) rst_n = 1'b1;
        end
        chk("t2 no ldac", 32'(ldac_cnt_a), 32'd0);
        chk("t2 no done", 32'(done_cnt_a), 32'd0);

        // T3: full transaction after the abort.
        bus_a.dacA_word = 12'h0F0; bus_a.dacB_word = 12'h70E;
        bus_a.start = 1'b1; clr_a = 1'b1; t0_a = cyc;
        for (int r = 1; r <= 143; r++) begin
            @(posedge clk); #1;
            clr_a = 1'b0;
            bus_a.start = 1'b0;
        end
        chk("t3 done@143", 32'(bus_a.done), 32'd1);
        chk("t3 rises", 32'(rises_a), 32'd32);
        chk("t3 frames", data_a, 32'h30F0_B70E);
        chk("t3 ldac width", 32'(ldac_cnt_a), 32'd2);

        // T4: CLK_DIV=1, CS_GAP=1 instance.
        bus_b.dacA_word = 12'h000; bus_b.dacB_word = 12'hFFF;
        bus_b.start = 1'b1; clr_b = 1'b1; t0_b = cyc;
        for (int r = 1; r <= 72; r++) begin
            @(posedge clk); #1;
            clr_b = 1'b0;
            bus_b.start = 1'b0;
        end
        chk("t4 done@72", 32'(bus_b.done), 32'd1);
        chk("t4 rises", 32'(rises_b), 32'd32);
        chk("t4 frames", data_b, 32'h3000_BFFF);
        chk("t4 ldac first", 32'(ldac_first_b), 32'd71);
        chk("t4 ldac last", 32'(ldac_last_b), 32'd71);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
